// File: rtl/inc_add16_pkg.sv
// Shared constants and op-mode encoding for the 16-bit increment/add unit.
package inc_add16_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_INC = 1'b1
  } op_mode_e;

endpackage : inc_add16_pkg

// File: rtl/inc_add16_unit_ha_cell.sv
// Gate-level half-adder cell; the only arithmetic primitive of the datapath.
module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule : ha_cell

// File: rtl/inc_add16_unit.sv
// Registered WIDTH-bit incrementer / adder built from half-adder cells, 1-cycle latency.
// Optional macro INC_ADD16_OVF_EN adds a registered signed-overflow output ovf.
module inc_add16_unit
  import inc_add16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             op_inc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
`ifdef INC_ADD16_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  op_mode_e         op_mode;
  logic [WIDTH-1:0] inc_r;
  logic             inc_c_msb;
  logic             inc_cout;
  logic [WIDTH-1:0] add_s;
  logic             add_c_msb;
  logic             add_cout;

  logic [WIDTH-1:0] res_p0;
  logic             cout_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             vld_p1;

  assign op_mode = op_mode_e'(op_inc);

  // Stage p0: increment chain. Bit 0 is a plain inverter whose carry is a[0].
  assign inc_r[0] = ~a[0];

  for (genvar i = 1; i <= WIDTH - 2; i++) begin : g_inc
    logic ci;
    logic c;
    if (i == 1) begin : g_first
      assign ci = a[0];
    end else begin : g_next
      assign ci = g_inc[i-1].c;
    end
    ha_cell u_ha (.x(a[i]), .y(ci), .s(inc_r[i]), .c(c));
  end

  if (WIDTH == 2) begin : g_inc_short
    assign inc_c_msb = a[0];
  end else begin : g_inc_long
    assign inc_c_msb = g_inc[WIDTH-2].c;
  end

  assign inc_r[WIDTH-1] = a[WIDTH-1] ^ inc_c_msb;
  assign inc_cout       = a[WIDTH-1] & inc_c_msb;

  // Full-adder ripple: two half adders per bit, carries ORed.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic ci;
    logic hs;
    logic hc0;
    logic hc1;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = cin;
    end else begin : g_upper
      assign ci = g_fa[i-1].co;
    end
    ha_cell u_ha0 (.x(a[i]), .y(b[i]), .s(hs), .c(hc0));
    ha_cell u_ha1 (.x(hs), .y(ci), .s(add_s[i]), .c(hc1));
    assign co = hc0 | hc1;
  end

  assign add_c_msb = g_fa[WIDTH-1].ci;
  assign add_cout  = g_fa[WIDTH-1].co;

  always_comb begin
    res_p0  = add_s;
    cout_p0 = add_cout;
    if (op_mode == OP_INC) begin
      res_p0  = inc_r;
      cout_p0 = inc_cout;
    end
  end

`ifdef INC_ADD16_OVF_EN
  logic ovf_p0;
  logic ovf_p1;

  // Signed overflow is carry into the MSB differing from carry out of it.
  always_comb begin
    ovf_p0 = add_c_msb ^ add_cout;
    if (op_mode == OP_INC) begin
      ovf_p0 = inc_c_msb ^ inc_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_p1 <= 1'b0;
    end else if (in_valid) begin
      ovf_p1 <= ovf_p0;
    end
  end

  assign ovf = ovf_p1;
`else
  logic unused_msb_carry;
  assign unused_msb_carry = add_c_msb;
`endif

  // Stage p1: result register; data holds whenever no new operation arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= res_p0;
        cout_p1 <= cout_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign sum       = sum_p1;
  assign cout      = cout_p1;

endmodule : inc_add16_unit

// File: tb/tb_inc_add16_unit.sv
// Scoreboard bench for inc_add16_unit: expected results queued at drive time, popped at output.
module tb_inc_add16_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        op_inc;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic [15:0] sum;
  logic        cout;
`ifdef INC_ADD16_OVF_EN
  logic        ovf;
`endif

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_tests;
  int   n_fail;

  inc_add16_unit #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .op_inc   (op_inc),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .sum      (sum),
`ifdef INC_ADD16_OVF_EN
    .ovf      (ovf),
`endif
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic op, input logic [15:0] x, input logic [15:0] y,
                                 input logic c);
    exp_t        e;
    logic [16:0] full;
    if (op) full = {1'b0, x} + 17'd1;
    else    full = {1'b0, x} + {1'b0, y} + {16'd0, c};
    e.sum  = full[15:0];
    e.cout = full[16];
    if (op) e.ovf = (x == 16'h7FFF);
    else    e.ovf = (x[15] == y[15]) && (full[15] != x[15]);
    return e;
  endfunction

  task automatic drive_op(input logic op, input logic [15:0] x, input logic [15:0] y,
                          input logic c);
    in_valid = 1'b1;
    op_inc   = op;
    a        = x;
    b        = y;
    cin      = c;
    sb.push_back(model(op, x, y, c));
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_op(1'b1, 16'h1233, 16'h0000, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || sum !== e.sum || cout !== e.cout) begin
      n_fail++;
      $display("FAIL pre_reset_op got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b",
               out_valid, sum, cout, e.sum, e.cout);
    end
    drive_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got v=%b sum=%h cout=%b want v=0 sum=0000 cout=0",
               out_valid, sum, cout);
    end
`ifdef INC_ADD16_OVF_EN
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_ovf got %b want 0", ovf);
    end
`endif
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_release got v=%b sum=%h want v=0 sum=0000", out_valid, sum);
    end
    drive_op(1'b0, 16'h0102, 16'h0304, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || sum !== e.sum || cout !== e.cout) begin
      n_fail++;
      $display("FAIL first_after_reset got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b",
               out_valid, sum, cout, e.sum, e.cout);
    end
    last_exp = e;
  endtask

  task automatic test_increment();
    logic [15:0] src [4];
    logic [15:0] want[4];
    exp_t        e;
    src  = '{16'h0000, 16'h0001, 16'h00FF, 16'h8000};
    want = '{16'h0001, 16'h0002, 16'h0100, 16'h8001};
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b1, src[i], 16'hA5A5, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || sum !== want[i] || cout !== 1'b0 || e.sum !== want[i]) begin
        n_fail++;
        $display("FAIL inc_seq[%0d] got v=%b sum=%h cout=%b want v=1 sum=%h cout=0",
                 i, out_valid, sum, cout, want[i]);
      end
      last_exp = e;
    end
  endtask

  task automatic test_boundaries();
    logic        op_t [6];
    logic [15:0] a_t  [6];
    logic [15:0] b_t  [6];
    logic        c_t  [6];
    logic [15:0] s_w  [6];
    logic        co_w [6];
    logic        ov_w [6];
    exp_t        e;
    op_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    a_t  = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h8000, 16'hFFFF};
    b_t  = '{16'h0000, 16'h0000, 16'h4321, 16'h0001, 16'h8000, 16'h0000};
    c_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    s_w  = '{16'h0000, 16'h8000, 16'h5556, 16'h0000, 16'h0000, 16'h0000};
    co_w = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ov_w = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_op(op_t[i], a_t[i], b_t[i], c_t[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || sum !== s_w[i] || cout !== co_w[i]) begin
        n_fail++;
        $display("FAIL boundary[%0d] got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b",
                 i, out_valid, sum, cout, s_w[i], co_w[i]);
      end
`ifdef INC_ADD16_OVF_EN
      n_tests++;
      if (ovf !== ov_w[i]) begin
        n_fail++;
        $display("FAIL boundary_ovf[%0d] got %b want %b", i, ovf, ov_w[i]);
      end
`else
      if (e.ovf !== ov_w[i]) $display("note: model ovf disagrees at %0d", i);
`endif
      last_exp = e;
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a   = 16'h1111 * (i + 1);
      b   = 16'h2222 * (i + 1);
      cin = i[0];
      op_inc = ~i[0];
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0 || sum !== last_exp.sum || cout !== last_exp.cout) begin
        n_fail++;
        $display("FAIL hold[%0d] got v=%b sum=%h cout=%b want v=0 sum=%h cout=%b",
                 i, out_valid, sum, cout, last_exp.sum, last_exp.cout);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] x;
    logic [15:0] y;
    int          sel;
    int          errs;
    errs = 0;
    for (int i = 0; i < 1200; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       x = 16'hFFFF;
        1:       x = 16'h7FFF;
        2:       x = 16'h8000;
        3:       x = 16'h0000;
        default: x = 16'($urandom);
      endcase
      y = (sel == 4) ? 16'hFFFF : 16'($urandom);
      drive_op(1'($urandom), x, y, 1'($urandom));
      @(posedge clk); #1;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_queue[%0d] got empty queue want one entry", i);
        continue;
      end
      e = sb.pop_front();
      if (out_valid !== 1'b1 || sum !== e.sum || cout !== e.cout) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL b2b[%0d] got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b",
                   i, out_valid, sum, cout, e.sum, e.cout);
        errs++;
      end
`ifdef INC_ADD16_OVF_EN
      n_tests++;
      if (ovf !== e.ovf) begin
        n_fail++;
        if (errs < 10) $display("FAIL b2b_ovf[%0d] got %b want %b", i, ovf, e.ovf);
        errs++;
      end
`endif
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op_inc   = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    last_exp = '0;
    test_reset();
    test_increment();
    test_boundaries();
    test_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_inc_add16_unit
